fft_stream_ctrl: RTL and testbench

FFT_STREAM_CTRL -- requirements
Module: fft_stream_ctrl

---
 rtl/fft_stream_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fft_stream_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl: streaming wrapper around a pipelined FFT core.
// Feeds input samples to the core under a clock enable, aligns the core's output frames on its
// sync flag, and buffers bins in a small FIFO whose free space throttles the core, so an output
// is never dropped. A flush request pads any partial frame with zeros, drains every frame
// already started, then resets the core and re-primes.
//
// Ports
//   i_clk, i_reset                      clock, asynchronous active-high reset
//   i_s_valid/o_s_ready/i_s_data        input sample stream {real, imag}
//   o_m_valid/i_m_ready/o_m_data/o_m_last  output bin stream, last on bin N-1
//   i_flush                             level request to drain the pipeline
//   o_fft_reset/o_fft_ce/o_fft_sample   FFT core sync reset, clock enable and sample
//   i_fft_result/i_fft_sync             FFT core output, sync marks bin 0
//   o_busy, o_sync_err, o_frames        status: not idle, sticky sync error, frames emitted
module fft_stream_ctrl #(
    parameter int unsigned LGFFT  = 10,
    parameter int unsigned IWIDTH = 12,
    parameter int unsigned OWIDTH = 16,
    parameter int unsigned LGFIFO = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [2*IWIDTH-1:0]   i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [2*OWIDTH-1:0]   o_m_data,
    output logic                  o_m_last,
    input  logic                  i_flush,
    output logic                  o_fft_reset,
    output logic                  o_fft_ce,
    output logic [2*IWIDTH-1:0]   o_fft_sample,
    input  logic [2*OWIDTH-1:0]   i_fft_result,
    input  logic                  i_fft_sync,
    output logic                  o_busy,
    output logic                  o_sync_err,
    output logic [15:0]           o_frames
);

    localparam int unsigned N     = 1 << LGFFT;
    localparam int unsigned DEPTH = 1 << LGFIFO;
    localparam logic [LGFFT-1:0] LastIdx = LGFFT'(N - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StPrime = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StFlush = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                fft_reset_q;
    logic                ce_dly_q;
    logic [LGFFT-1:0]    in_idx_q;
    logic [LGFFT-1:0]    out_idx_q;
    logic [3:0]          inflight_q;
    logic                sync_err_q;
    logic [15:0]         frames_q;
    logic [2*OWIDTH:0]   mem_q [DEPTH];
    logic [LGFIFO-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LGFIFO:0]     count_q;

    logic feeding, space, push, pop, frame_start, frame_done, exit_flush, bin_last;

    always_comb begin
        // No samples while the core sits in its reset cycle after a flush; they would be lost.
        feeding      = ((state_q == StPrime) || (state_q == StRun)) && !fft_reset_q;
        // The output of this cycle's enable lands next cycle, so reserve room for it and for
        // the output already in flight.
        space        = (32'(count_q) + 32'(ce_dly_q)) <= 32'(DEPTH - 2);
        o_s_ready    = space && feeding;
        o_fft_ce     = space && ((feeding && i_s_valid) || (state_q == StFlush));
        o_fft_sample = ((state_q == StPrime) || (state_q == StRun)) ? i_s_data : '0;
        o_m_valid    = count_q != '0;
        o_m_data     = mem_q[rd_ptr_q][2*OWIDTH-1:0];
        o_m_last     = mem_q[rd_ptr_q][2*OWIDTH];
        bin_last     = out_idx_q == LastIdx;

        push = 1'b0;
        unique case (state_q)
            // A stale output that arrives during the core reset cycle must not start a frame.
            StPrime: push = ce_dly_q && i_fft_sync && !fft_reset_q;
            StRun:   push = ce_dly_q;
            StFlush: push = ce_dly_q && (inflight_q != '0);
            default: push = 1'b0;
        endcase

        pop         = o_m_valid && i_m_ready;
        frame_start = o_fft_ce && (state_q != StFlush) && (in_idx_q == '0);
        frame_done  = push && bin_last;
        exit_flush  = (state_q == StFlush) && (inflight_q == '0);

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fft_reset_q) state_d = StPrime;
            StPrime: if (push) state_d = StRun;
            StRun:   if (i_flush) state_d = StFlush;
            StFlush: if (exit_flush) state_d = StPrime;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            fft_reset_q <= 1'b1;
            ce_dly_q    <= 1'b0;
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            inflight_q  <= '0;
            sync_err_q  <= 1'b0;
            frames_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fft_reset_q <= exit_flush;
            ce_dly_q    <= o_fft_ce;

            if (exit_flush) begin
                in_idx_q <= '0;
            end else if (o_fft_ce) begin
                in_idx_q <= in_idx_q + LGFFT'(1);
            end

            if (exit_flush) begin
                out_idx_q <= '0;
            end else if (push) begin
                out_idx_q <= out_idx_q + LGFFT'(1);
            end

            // Frames started but not yet fully pushed; frozen against new starts in flush so it
            // counts down to the end of the drain.
            if (exit_flush) begin
                inflight_q <= '0;
            end else begin
                inflight_q <= inflight_q + 4'(frame_start) - 4'(frame_done);
            end

            if (push && (state_q != StPrime) && (i_fft_sync != (out_idx_q == '0))) begin
                sync_err_q <= 1'b1;
            end

            if (pop && o_m_last) begin
                frames_q <= frames_q + 16'd1;
            end

            if (push) wr_ptr_q <= wr_ptr_q + LGFIFO'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + LGFIFO'(1);
            count_q <= count_q + (LGFIFO + 1)'(push) - (LGFIFO + 1)'(pop);
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bin_last, i_fft_result};
        end
    end

    assign o_fft_reset = fft_reset_q;
    assign o_busy      = state_q != StIdle;
    assign o_sync_err  = sync_err_q;
    assign o_frames    = frames_q;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl. A stand-in FFT core (one-frame latency, bin k = x[0] + x[k],
// bin 0 = x[0]) is modelled here, and a frame-level scoreboard predicts every output beat.
module tb_fft_stream_ctrl;

    localparam int N  = 1024;
    localparam logic [23:0] Imp = 24'h12CFF9;  // real 300, imag -7

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, m_valid, m_ready, m_last, flush;
    logic        fft_reset, fft_ce, fft_sync, busy, sync_err;
    logic [23:0] s_data, fft_sample;
    logic [31:0] m_data, fft_result;
    logic [15:0] frames;

    always #5 clk = ~clk;

    fft_stream_ctrl dut (
        .i_clk(clk), .i_reset(rst),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_last(m_last),
        .i_flush(flush),
        .o_fft_reset(fft_reset), .o_fft_ce(fft_ce), .o_fft_sample(fft_sample),
        .i_fft_result(fft_result), .i_fft_sync(fft_sync),
        .o_busy(busy), .o_sync_err(sync_err), .o_frames(frames)
    );

    int checks = 0;
    int errors = 0;

    // Core model state
    logic [23:0] cur [N];
    logic [23:0] prv [N];
    bit          have_prv = 0;
    int          widx = 0;
    bit          inject = 0;

    // Scoreboard state
    logic [32:0] expq [$];
    logic [23:0] frm [$];
    int          acc_total = 0;
    int          popped = 0;
    int          pulses = 0;
    bit          prev_frst = 0;
    bit          ce_chk_en = 1;
    bit          flush_phase = 0;
    logic [31:0] last_beat = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bin_of(input logic [23:0] x0, input logic [23:0] xk,
                                           input int k);
        int r, i;
        r = int'($signed(x0[23:12]));
        i = int'($signed(x0[11:0]));
        if (k != 0) begin
            r += int'($signed(xk[23:12]));
            i += int'($signed(xk[11:0]));
        end
        return {r[15:0], i[15:0]};
    endfunction

    task automatic close_frame();
        for (int k = 0; k < N; k++) expq.push_back({k == N - 1, bin_of(frm[0], frm[k], k)});
        frm.delete();
    endtask

    // One clock: sample at negedge+1, update models, advance to the next negedge.
    task automatic tick();
        logic acc, ce, frst, upd, nsync;
        logic [23:0] smp;
        logic [31:0] nres;
        logic [32:0] head;
        #1;
        acc  = s_valid && s_ready;
        ce   = fft_ce;
        smp  = fft_sample;
        frst = fft_reset;
        if (ce_chk_en) chk("ce_vs_accept", 64'(ce), 64'(acc));
        if (flush_phase) chk("no_accept_in_flush", 64'(acc), 64'(0));
        if (m_valid && m_ready) begin
            chk("model_has_beat", 64'(expq.size() != 0), 64'(1));
            if (expq.size() != 0) begin
                head = expq.pop_front();
                chk("beat_data", 64'(m_data), 64'(head[31:0]));
                chk("beat_last", 64'(m_last), 64'(head[32]));
            end
            last_beat = m_data;
            popped++;
        end
        if (acc) begin
            frm.push_back(s_data);
            acc_total++;
            if (frm.size() == N) close_frame();
        end
        if (frst) begin
            frm.delete();
            flush_phase = 0;
            if (!prev_frst) pulses++;
        end
        prev_frst = frst;
        upd = 0;
        nres = '0;
        nsync = 0;
        if (frst) begin
            widx = 0;
            have_prv = 0;
        end else if (ce) begin
            nres  = have_prv ? bin_of(prv[0], prv[widx], widx) : '0;
            nsync = have_prv && ((widx == 0) || (inject && widx == 5));
            if (have_prv && inject && widx == 5) inject = 0;
            upd = 1;
            cur[widx] = smp;
            widx++;
            if (widx == N) begin
                for (int k = 0; k < N; k++) prv[k] = cur[k];
                have_prv = 1;
                widx = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (upd) begin
            fft_result = nres;
            fft_sync   = nsync;
        end
    endtask

    initial begin
        int n0, p0, p_start, cyc;
        rst = 0; s_valid = 0; s_data = '0; m_ready = 0; flush = 0;
        fft_result = '0; fft_sync = 0;
        #1 rst = 1;
        #1;
        chk("rst_fft_reset", 64'(fft_reset), 64'(1));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_fft_ce", 64'(fft_ce), 64'(0));
        chk("rst_sync_err", 64'(sync_err), 64'(0));
        chk("rst_frames", 64'(frames), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        repeat (3) tick();
        rst = 0;
        #1 chk("fft_reset_held", 64'(fft_reset), 64'(1));
        tick();
        chk("fft_reset_released", 64'(fft_reset), 64'(0));
        chk("still_idle", 64'(busy), 64'(0));
        tick();
        chk("prime_busy", 64'(busy), 64'(1));
        chk("prime_ready", 64'(s_ready), 64'(1));

        // Three impulse frames, sink always ready
        n0 = acc_total; p0 = popped; cyc = 0;
        s_valid = 1; m_ready = 1;
        while (acc_total - n0 < 3 * N && cyc < 4 * N) begin
            s_data = ((acc_total - n0) % N == 0) ? Imp : 24'h0;
            tick();
            cyc++;
        end
        chk("B_accepted", 64'(acc_total - n0), 64'(3 * N));
        s_valid = 0;
        repeat (20) tick();
        chk("B_beats", 64'(popped - p0), 64'(2 * N));
        chk("B_frames", 64'(frames), 64'(2));
        chk("B_sync_err", 64'(sync_err), 64'(0));
        chk("B_dc_bin", 64'(last_beat), 64'(32'h012CFFF9));
        chk("B_pending", 64'(expq.size()), 64'(N));

        // Random data, random valid and ready, ending half-way through a frame
        n0 = acc_total; cyc = 0;
        while (acc_total - n0 < 2 * N + N / 2 && cyc < 20 * N) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = 24'($urandom);
            tick();
            cyc++;
        end
        chk("C_accepted", 64'(acc_total - n0), 64'(2 * N + N / 2));
        chk("C_sync_err", 64'(sync_err), 64'(0));

        // Flush: partial frame padded, everything started is drained, core reset once
        s_valid = 0; flush = 1;
        tick();
        flush = 0;
        while (frm.size() != 0 && frm.size() < N) frm.push_back(24'h0);
        close_frame();
        ce_chk_en = 0; flush_phase = 1; p_start = pulses; cyc = 0;
        while (!(pulses > p_start && expq.size() == 0 && !m_valid && !fft_reset)
               && cyc < 20 * N) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        ce_chk_en = 1;
        chk("F_pulses", 64'(pulses - p_start), 64'(1));
        chk("F_drained", 64'(expq.size()), 64'(0));
        chk("F_total_beats", 64'(popped), 64'(6 * N));
        chk("F_frames", 64'(frames), 64'(6));
        chk("F_ready_back", 64'(s_ready), 64'(1));
        chk("F_busy", 64'(busy), 64'(1));
        m_ready = 1;
        repeat (8) tick();
        chk("F_single_pulse", 64'(pulses - p_start), 64'(1));

        // Re-prime, then a misplaced sync from the core
        n0 = acc_total; cyc = 0; s_valid = 1;
        while (acc_total - n0 < N + 20 && cyc < 3 * N) begin
            s_data = 24'($urandom);
            tick();
            cyc++;
        end
        chk("D_accepted", 64'(acc_total - n0), 64'(N + 20));
        chk("D_sync_err_clean", 64'(sync_err), 64'(0));
        inject = 1;
        n0 = acc_total; cyc = 0;
        while (acc_total - n0 < N && cyc < 3 * N) begin
            s_data = 24'($urandom);
            tick();
            cyc++;
        end
        chk("D_injected", 64'(inject), 64'(0));
        chk("D_sync_err_set", 64'(sync_err), 64'(1));
        repeat (50) tick();
        chk("D_sync_err_sticky", 64'(sync_err), 64'(1));

        // Asynchronous reset mid-frame with data queued
        m_ready = 0;
        repeat (4) tick();
        chk("E_m_valid_before", 64'(m_valid), 64'(1));
        #2 rst = 1;
        #1;
        chk("E_m_valid", 64'(m_valid), 64'(0));
        chk("E_fft_ce", 64'(fft_ce), 64'(0));
        chk("E_fft_reset", 64'(fft_reset), 64'(1));
        chk("E_s_ready", 64'(s_ready), 64'(0));
        chk("E_sync_err", 64'(sync_err), 64'(0));
        chk("E_frames", 64'(frames), 64'(0));
        chk("E_busy", 64'(busy), 64'(0));
        expq.delete();
        frm.delete();
        s_valid = 0;
        @(negedge clk);
        repeat (2) tick();
        rst = 0;
        repeat (2) tick();
        p0 = popped; n0 = acc_total; cyc = 0;
        m_ready = 1; s_valid = 1;
        while (acc_total - n0 < 2 * N + 10 && cyc < 3 * N) begin
            s_data = (frm.size() == 0) ? Imp : 24'($urandom);
            tick();
            cyc++;
        end
        s_valid = 0;
        repeat (20) tick();
        chk("E2_beats", 64'(popped - p0), 64'(N + 10));
        chk("E2_frames", 64'(frames), 64'(1));
        chk("E2_sync_err", 64'(sync_err), 64'(0));
        chk("E2_pending", 64'(expq.size()), 64'(N - 10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
